// File: rtl/sys_link_host.sv
// rtl/sys_link_host.sv - host side of the two-wire sys link: frames a byte onto one, waits for ack on two
module sys_link_host #(
    parameter int BIT_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       one,
    input  logic       two,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_ACK,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_two;

    logic [CW-1:0] cyc, cyc_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [WW-1:0] wait_cnt, wait_cnt_next;
    logic [7:0]    shreg, shreg_next;
    logic          bit_end;

    logic one_next, done_next, ack_next, timeout_next, ready_next;

    assign sync_two = sync_q[SYNC_STAGES-1];
    assign bit_end  = (cyc == CYC_LAST);

    // Bring the asynchronous ack line into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], two};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counters, shifter and next values of the registered outputs
    always_comb begin
        state_next    = state;
        cyc_next      = cyc;
        bit_cnt_next  = bit_cnt;
        wait_cnt_next = wait_cnt;
        shreg_next    = shreg;
        done_next     = 1'b0;
        ack_next      = 1'b0;
        timeout_next  = 1'b0;

        case (state)
            S_IDLE: begin
                cyc_next = '0;
                if (tx_valid && tx_ready) begin
                    shreg_next   = tx_data;
                    bit_cnt_next = 3'd0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_next     = '0;
                    bit_cnt_next = 3'd0;
                    state_next   = S_DATA;
                end else begin
                    cyc_next = cyc + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_next   = '0;
                    shreg_next = {shreg[6:0], 1'b0};
                    if (bit_cnt == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end else begin
                    cyc_next = cyc + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cyc_next      = '0;
                    wait_cnt_next = '0;
                    state_next    = S_WAIT_ACK;
                end else begin
                    cyc_next = cyc + CW'(1);
                end
            end
            S_WAIT_ACK: begin
                // An ack on the final wait cycle still counts as an ack
                if (sync_two) begin
                    state_next = S_RESP;
                    done_next  = 1'b1;
                    ack_next   = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next   = S_RESP;
                    done_next    = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + WW'(1);
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // The line follows the current state one cycle later, so an accept
        // shows on one at the following edge
        case (state)
            S_START: one_next = 1'b0;
            S_DATA:  one_next = shreg[7];
            default: one_next = 1'b1;
        endcase

        ready_next = (state_next == S_IDLE);
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= '0;
            bit_cnt  <= 3'd0;
            wait_cnt <= '0;
            shreg    <= 8'd0;
            one      <= 1'b1;
            tx_ready <= 1'b1;
            done     <= 1'b0;
            ack_ok   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            cyc      <= cyc_next;
            bit_cnt  <= bit_cnt_next;
            wait_cnt <= wait_cnt_next;
            shreg    <= shreg_next;
            one      <= one_next;
            tx_ready <= ready_next;
            done     <= done_next;
            ack_ok   <= ack_next;
            timeout  <= timeout_next;
        end
    end

endmodule

// File: tb/tb_sys_link_host.sv
// tb/tb_sys_link_host.sv - directed self-checking bench for sys_link_host
module tb_sys_link_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic [7:0] tx_data4;
    logic       tx_valid4, tx_ready4, one4, two4, done4, ack4, to4;
    logic [7:0] tx_data1;
    logic       tx_valid1, tx_ready1, one1, two1, done1, ack1, to1;

    int total = 0;
    int bad   = 0;

    sys_link_host #(.BIT_CYCLES(4), .ACK_TIMEOUT(16), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
        .one(one4), .two(two4),
        .done(done4), .ack_ok(ack4), .timeout(to4)
    );

    sys_link_host #(.BIT_CYCLES(1), .ACK_TIMEOUT(16), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .one(one1), .two(two1),
        .done(done1), .ack_ok(ack1), .timeout(to1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bit j: start 0, data MSB first, stop 1
    function automatic logic fbit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return d[8-j];
    endfunction

    task automatic send4(input logic [7:0] d);
        chk("pre_accept_ready", tx_ready4, 1);
        tx_data4  = d;
        tx_valid4 = 1'b1;
        tick();
        tx_valid4 = 1'b0;
        chk("accept_ready_low", tx_ready4, 0);
        chk("accept_one_still_high", one4, 1);
    endtask

    task automatic frame4(input logic [7:0] d, input string tag);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk(tag, one4, fbit(d, j));
            end
        end
    endtask

    task automatic timeout4(input string tag);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk({tag, "_wait_one"}, one4, 1);
            chk({tag, "_wait_done"}, done4, 0);
        end
        tick();
        chk({tag, "_done"}, done4, 1);
        chk({tag, "_timeout"}, to4, 1);
        chk({tag, "_ack"}, ack4, 0);
        chk({tag, "_one"}, one4, 1);
        tick();
        chk({tag, "_done_clear"}, done4, 0);
        chk({tag, "_timeout_clear"}, to4, 0);
        chk({tag, "_ready"}, tx_ready4, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_data4  = 8'h00; tx_valid4 = 1'b0; two4 = 1'b0;
        tx_data1  = 8'h00; tx_valid1 = 1'b0; two1 = 1'b0;
        repeat (2) tick();

        chk("rst_ready4", tx_ready4, 1);
        chk("rst_one4", one4, 1);
        chk("rst_done4", done4, 0);
        chk("rst_ack4", ack4, 0);
        chk("rst_to4", to4, 0);
        chk("rst_ready1", tx_ready1, 1);
        chk("rst_one1", one1, 1);
        chk("rst_done1", done1, 0);

        rst_n = 1'b1;
        tick();

        // Basic ack of 8'hA5, two raised 3 cycles into WAIT_ACK
        send4(8'hA5);
        frame4(8'hA5, "basic_frame");
        repeat (3) tick();
        two4 = 1'b1;
        repeat (2) tick();
        chk("basic_done_early", done4, 0);
        tick();
        chk("basic_done", done4, 1);
        chk("basic_ack", ack4, 1);
        chk("basic_to", to4, 0);
        chk("basic_one", one4, 1);
        chk("basic_ready_resp", tx_ready4, 0);
        two4 = 1'b0;
        tick();
        chk("basic_done_clear", done4, 0);
        chk("basic_ack_clear", ack4, 0);
        chk("basic_ready", tx_ready4, 1);

        // Timeout with two held low
        send4(8'h3C);
        frame4(8'h3C, "to_frame");
        timeout4("to");

        // Ack first visible on the final wait cycle
        send4(8'h96);
        frame4(8'h96, "race_frame");
        repeat (13) tick();
        two4 = 1'b1;
        repeat (2) tick();
        chk("race_done_early", done4, 0);
        tick();
        chk("race_done", done4, 1);
        chk("race_ack", ack4, 1);
        chk("race_to", to4, 0);
        two4 = 1'b0;
        tick();
        chk("race_ready", tx_ready4, 1);

        // Early ack ignored, busy valid with a changing byte ignored
        chk("busy_pre_ready", tx_ready4, 1);
        tx_data4  = 8'hC3;
        tx_valid4 = 1'b1;
        tick();
        tx_data4 = 8'hFF;
        chk("busy_accept_ready", tx_ready4, 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("busy_frame", one4, fbit(8'hC3, k / 4));
            if (k == 12) two4 = 1'b1;
            if (k == 14) two4 = 1'b0;
        end
        chk("busy_ready_low", tx_ready4, 0);
        timeout4("early");
        tick();
        chk("second_accept_ready_low", tx_ready4, 0);
        tx_valid4 = 1'b0;
        frame4(8'hFF, "second_frame");
        timeout4("second");

        // Reset during data bit 5 of 8'h00
        send4(8'h00);
        repeat (14) tick();
        chk("abort_bit5_low", one4, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_one", one4, 1);
        chk("abort_ready", tx_ready4, 1);
        chk("abort_done", done4, 0);
        tick();
        chk("abort_done_hold", done4, 0);
        chk("abort_one_hold", one4, 1);
        rst_n = 1'b1;
        tick();
        chk("abort_post_done", done4, 0);
        send4(8'h81);
        frame4(8'h81, "abort_resend_frame");
        two4 = 1'b1;
        repeat (2) tick();
        chk("resend_done_early", done4, 0);
        tick();
        chk("resend_done", done4, 1);
        chk("resend_ack", ack4, 1);
        chk("resend_to", to4, 0);
        two4 = 1'b0;
        tick();
        chk("resend_ready", tx_ready4, 1);

        // BIT_CYCLES=1 back-to-back, ack immediately
        chk("bc1_pre_ready", tx_ready1, 1);
        tx_data1  = 8'h01;
        tx_valid1 = 1'b1;
        two1      = 1'b1;
        tick();
        tx_data1 = 8'h80;
        chk("bc1_accept_ready", tx_ready1, 0);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("bc1_frame01", one1, fbit(8'h01, j));
            chk("bc1_frame01_done", done1, 0);
        end
        tick();
        chk("bc1_done01", done1, 1);
        chk("bc1_ack01", ack1, 1);
        chk("bc1_to01", to1, 0);
        chk("bc1_one01", one1, 1);
        tick();
        chk("bc1_done01_clear", done1, 0);
        chk("bc1_ready01", tx_ready1, 1);
        tick();
        chk("bc1_accept80", tx_ready1, 0);
        tx_valid1 = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("bc1_frame80", one1, fbit(8'h80, j));
            chk("bc1_frame80_done", done1, 0);
        end
        tick();
        chk("bc1_done80", done1, 1);
        chk("bc1_ack80", ack1, 1);
        tick();
        chk("bc1_done80_clear", done1, 0);
        chk("bc1_ready80", tx_ready1, 1);
        two1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_link_host.md
Name: sys_link_host

Overview:
- Host-side peer of the two-wire `sys` link. A device on that link drives `two` and receives `one`. This block drives `one` and samples `two`.
- Takes a byte on a valid/ready port and serialises it onto `one` as a framed bit stream.
- After the frame, waits a bounded time for the device to acknowledge on `two`, then reports the result.
- Sits between a host command source and the interface instance connected to the device.

Parameters:
- BIT_CYCLES, 4, clock cycles per serial bit on `one`; legal range >= 1.
- ACK_TIMEOUT, 16, clock cycles allowed in the ack-wait phase before declaring timeout; legal range >= 1.
- SYNC_STAGES, 2, flop stages on the `two` input synchroniser; legal range >= 2.

Ports:
- clk  input  1  Single clock for all logic.
- rst_n  input  1  Reset, asynchronous assert, active-low; deassertion is synchronised externally.
- tx_data  input  8  Byte to send; sampled only on accept.
- tx_valid  input  1  Byte available.
- tx_ready  output  1  Block can accept; high only in IDLE.
- one  output  1  Serial line to the device; idles high.
- two  input  1  Ack line from the device; asynchronous; passes through a SYNC_STAGES synchroniser before use.
- done  output  1  One-cycle pulse when a transaction ends.
- ack_ok  output  1  Valid with `done`: 1 = device acknowledged.
- timeout  output  1  Valid with `done`: 1 = no ack within ACK_TIMEOUT.

Behaviour:
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - state = IDLE, tx_ready = 1, one = 1.
  - done = 0, ack_ok = 0, timeout = 0.
  - Synchroniser flops = 0; bit and cycle counters = 0.
- Accept: `tx_valid & tx_ready` at edge N.
  - `tx_data` is latched into the shift register.
  - State goes to START; `tx_ready` = 0 from edge N.
  - `one` falls at edge N+1 (one-cycle latency).
- Frame, MSB first, each bit held exactly BIT_CYCLES clocks:
  - start bit = 0;
  - data[7] … data[0];
  - stop bit = 1.
  - Total 10*BIT_CYCLES clocks.
- States:
  - IDLE -> START on accept.
  - START -> DATA after BIT_CYCLES.
  - DATA -> STOP after 8 bits (bit counter 0..7; shift on each bit boundary).
  - STOP -> WAIT_ACK after BIT_CYCLES.
  - WAIT_ACK -> RESP on synchronised `two` = 1, or when the wait counter reaches ACK_TIMEOUT-1.
  - RESP -> IDLE after exactly one cycle.
- Counters:
  - Cycle counter is $clog2(BIT_CYCLES+1) bits wide and resets to 0 on every bit boundary.
  - Wait counter is $clog2(ACK_TIMEOUT+1) bits wide, cleared on entry to WAIT_ACK, saturates, never wraps.
- Ack sampling:
  - Only the synchronised `two` observed during WAIT_ACK counts.
  - `two` high during START/DATA/STOP/IDLE is ignored; no error is flagged.
  - Ack seen on the first WAIT_ACK cycle is valid.
- Ack and timeout on the same cycle (final wait cycle): ack wins, giving ack_ok = 1, timeout = 0.
- RESP cycle:
  - done = 1 with exactly one of ack_ok or timeout = 1.
  - All three flags return to 0 the next cycle.
  - `one` = 1 throughout WAIT_ACK and RESP.
  - `tx_ready` rises on the edge leaving RESP.
  - Minimum accept-to-next-accept: 10*BIT_CYCLES + 2 + wait cycles.
- `tx_valid` while busy: ignored. `tx_data` changes while busy: no effect.
- BIT_CYCLES = 1: each bit lasts one clock; no off-by-one allowed.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). Any partial frame is abandoned and `done` is not pulsed.
- Reset mid-frame: `one` returns high immediately, so the device sees a frame with no stop bit.

Test Plan:
- Basic ack: BIT_CYCLES=4, send 8'hA5, device raises `two` 3 cycles into WAIT_ACK -> `one` = 0,1,0,1,0,0,1,0,1,1 with each bit 4 clocks; then done=1, ack_ok=1, timeout=0 for exactly one cycle; tx_ready returns to 1.
- Timeout: send 8'h3C, `two` held 0 -> done=1, timeout=1, ack_ok=0 exactly 16 cycles after WAIT_ACK entry; `one` stays 1 throughout.
- Race: `two` rises so its synchronised value first appears on wait cycle 15 (the last) -> ack_ok=1, timeout=0.
- Early/ignored ack and busy valid: `two` pulsed during DATA and `tx_valid` held high with 8'hFF during the frame -> pulse ignored, ends in timeout; the frame still carries the original byte; 8'hFF is accepted only after tx_ready returns.
- Reset abort: rst_n low during data bit 5 of 8'h00 -> same-cycle one=1, tx_ready=1, no done pulse; after release, 8'h81 is sent correctly.
- BIT_CYCLES=1: back-to-back bytes 8'h01, 8'h80, each acked immediately -> each frame exactly 10 clocks, one done per byte, correct bit order.
